// File: rtl/vga_fb_arbiter_pkg.sv
`default_nettype none
// vga_fb_arbiter_pkg: read-FSM state encoding and default widths shared with the VGA scan-out.
// Rev 1.0
package vga_fb_arbiter_pkg;

  localparam int VGA_FB_ADDR_W     = 19;
  localparam int VGA_FB_DATA_W     = 16;
  localparam int VGA_FB_WBUF_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PEND = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_fb_wbuf.sv
`default_nettype none
// vga_fb_wbuf: posted-write FIFO with registered empty/full flags and an occupancy count.
// Rev 1.0
module vga_fb_wbuf #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_nxt;
  logic             do_push;
  logic             do_pop;

  // Guarded here too so a caller bug can never corrupt the pointers.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = store[rd_ptr];

  always_comb begin
    level_nxt = level;
    case ({do_push, do_pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      empty <= (level_nxt == '0);
      full  <= (level_nxt == LVL_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// vga_fb_arbiter: single-port framebuffer arbiter, VGA fetch > CPU read > posted-write drain.
// Rev 1.0. Define VGA_FB_ARB_STATS_EN to add the saturating stat_stall counter port.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int ADDR_W     = VGA_FB_ADDR_W,
  parameter int DATA_W     = VGA_FB_DATA_W,
  parameter int WBUF_DEPTH = VGA_FB_WBUF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vga_req,
  input  logic [ADDR_W-1:0]             vga_addr,
  output logic [DATA_W-1:0]             vga_rdata,
  output logic                          vga_rvalid,
  input  logic                          cpu_valid,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic [DATA_W-1:0]             cpu_wdata,
  input  logic [DATA_W/8-1:0]           cpu_wstrb,
  output logic                          cpu_ready,
  output logic [DATA_W-1:0]             cpu_rdata,
  output logic                          mem_en,
  output logic [DATA_W/8-1:0]           mem_wstrb,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(WBUF_DEPTH):0]   wbuf_level
`ifdef VGA_FB_ARB_STATS_EN
  ,
  output logic [15:0]                   stat_stall
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int ENT_W  = ADDR_W + DATA_W + STRB_W;

  rd_state_t          state;
  rd_state_t          state_nxt;
  logic               wr_req;
  logic               rd_req;
  logic               rd_issue;
  logic               push;
  logic               pop;
  logic               wb_empty;
  logic               wb_full;
  logic [ENT_W-1:0]   wb_head;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_wdata;
  logic [STRB_W-1:0]  head_wstrb;
  logic               vga_p1;

  assign wr_req = cpu_valid & (|cpu_wstrb);
  assign rd_req = cpu_valid & ~(|cpu_wstrb);
  assign {head_addr, head_wdata, head_wstrb} = wb_head;

  vga_fb_wbuf #(
    .WIDTH (ENT_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({cpu_addr, cpu_wdata, cpu_wstrb}),
    .pop       (pop),
    .head      (wb_head),
    .empty     (wb_empty),
    .full      (wb_full),
    .level     (wbuf_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_en    = 1'b0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;

    case (state)
      IDLE: begin
        if (rd_req) begin
          state_nxt = RD_PEND;
        end else if (wr_req && !wb_full) begin
          push      = 1'b1;
          cpu_ready = 1'b1;
        end
      end
      RD_PEND: begin
        // Waiting for an empty buffer is what gives read-after-write ordering.
        if (wb_empty && !vga_req) begin
          rd_issue  = 1'b1;
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        cpu_ready = 1'b1;
        cpu_rdata = mem_rdata;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (vga_req) begin
      mem_en   = 1'b1;
      mem_addr = vga_addr;
    end else if (rd_issue) begin
      mem_en   = 1'b1;
      mem_addr = cpu_addr;
    end else if (!wb_empty) begin
      pop       = 1'b1;
      mem_en    = 1'b1;
      mem_addr  = head_addr;
      mem_wdata = head_wdata;
      mem_wstrb = head_wstrb;
    end

    // Outputs are forced quiet while reset is held, even with live requests.
    if (!rst) begin
      push      = 1'b0;
      pop       = 1'b0;
      cpu_ready = 1'b0;
      cpu_rdata = '0;
      mem_en    = 1'b0;
      mem_wstrb = '0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_p1     <= 1'b0;
      vga_rvalid <= 1'b0;
      vga_rdata  <= '0;
    end else begin
      vga_p1     <= vga_req;
      vga_rvalid <= vga_p1;
      if (vga_p1) vga_rdata <= mem_rdata;
    end
  end

`ifdef VGA_FB_ARB_STATS_EN
  logic stall_evt;

  assign stall_evt = vga_req & ((state == RD_PEND) | ~wb_empty);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_stall <= '0;
    end else if (stall_evt && (stat_stall != 16'hFFFF)) begin
      stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire
